// File: rtl/progmem_arbiter_pkg.sv
// Shared constants and helpers for the program-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package progmem_arbiter_pkg;

    localparam int PROGMEM_N_CORES = 4;
    localparam int INST_W_DEF      = 32;
    localparam int INST_ADDR_W_DEF = 16;

    // Increment that wraps explicitly at n-1 so non-power-of-two counts stay in range.
    function automatic int wrap_inc(input int v, input int n);
        return (v == n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/progmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; caller decides whether the pick is consumed.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any,
    output logic [PTR_W-1:0] idx
);

    int cand;

    // Scan from the farthest offset down so the nearest requester at/after ptr wins last.
    always_comb begin
        gnt  = '0;
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                any       = 1'b1;
                idx       = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/progmem_arbiter.sv
// Round-robin arbiter sharing one single-port program memory among N_CORES fetch stages.
// Latency: grant in cycle t, tagged response (core_rvalid + bypassed data) in cycle t+1.
// Backpressure: ungranted requesters see core_stall; one fetch issued per cycle total.
module progmem_arbiter
    import progmem_arbiter_pkg::*;
#(
    parameter int N_CORES     = PROGMEM_N_CORES,
    parameter int INST_W      = INST_W_DEF,
    parameter int INST_ADDR_W = INST_ADDR_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [N_CORES-1:0]             core_req,
    input  logic [N_CORES*INST_ADDR_W-1:0] core_addr,
    output logic [N_CORES-1:0]             core_gnt,
    output logic [N_CORES-1:0]             core_stall,
    output logic [N_CORES-1:0]             core_rvalid,
    output logic [N_CORES*INST_W-1:0]      core_rdata,
    output logic                           mem_en,
    output logic [INST_ADDR_W-1:0]         mem_addr,
    input  logic [INST_W-1:0]              mem_rdata
);

    localparam int PTR_W = $clog2(N_CORES);

    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic                      inflight_vld_q, inflight_vld_d;
    logic [PTR_W-1:0]          inflight_id_q, inflight_id_d;
    logic [INST_ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [N_CORES*INST_W-1:0] hold_q, hold_d;

    logic [N_CORES-1:0]        cand_req;
    logic [N_CORES-1:0]        pick_gnt;
    logic                      pick_any;
    logic [PTR_W-1:0]          pick_idx;
    logic [INST_ADDR_W-1:0]    win_addr;

    assign cand_req = core_req & {N_CORES{en}};

    rr_pick #(
        .N     (N_CORES),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (cand_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign win_addr = core_addr[int'(pick_idx)*INST_ADDR_W +: INST_ADDR_W];

    // Issue side: grant, memory strobe and next arbitration state.
    always_comb begin
        core_gnt       = pick_gnt;
        core_stall     = core_req & ~pick_gnt;
        mem_en         = pick_any;
        mem_addr       = pick_any ? win_addr : mem_addr_q;
        ptr_d          = ptr_q;
        inflight_vld_d = pick_any;
        inflight_id_d  = inflight_id_q;
        mem_addr_d     = mem_addr_q;
        if (pick_any) begin
            ptr_d         = PTR_W'(wrap_inc(int'(pick_idx), N_CORES));
            inflight_id_d = pick_idx;
            mem_addr_d    = win_addr;
        end
    end

    // Response side: the in-flight core sees memory data directly and latches it for later.
    always_comb begin
        core_rvalid = '0;
        core_rdata  = hold_q;
        hold_d      = hold_q;
        if (inflight_vld_q) begin
            core_rvalid[inflight_id_q]                      = 1'b1;
            core_rdata[int'(inflight_id_q)*INST_W +: INST_W] = mem_rdata;
            hold_d[int'(inflight_id_q)*INST_W +: INST_W]     = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q          <= '0;
            inflight_vld_q <= 1'b0;
            inflight_id_q  <= '0;
            mem_addr_q     <= '0;
            hold_q         <= '0;
        end else begin
            ptr_q          <= ptr_d;
            inflight_vld_q <= inflight_vld_d;
            inflight_id_q  <= inflight_id_d;
            mem_addr_q     <= mem_addr_d;
            hold_q         <= hold_d;
        end
    end

endmodule

// File: tb/tb_progmem_arbiter.sv
// Bench for progmem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a behavioural arbitration model.
module tb_progmem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [3:0]   core_req;
    logic [31:0]  core_addr;
    logic [3:0]   core_gnt;
    logic [3:0]   core_stall;
    logic [3:0]   core_rvalid;
    logic [127:0] core_rdata;
    logic         mem_en;
    logic [7:0]   mem_addr;
    logic [31:0]  mem_rdata;

    progmem_arbiter #(
        .N_CORES     (4),
        .INST_W      (32),
        .INST_ADDR_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_gnt    (core_gnt),
        .core_stall  (core_stall),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: data valid the cycle after mem_en.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state.
    int          m_ptr;
    int          m_pend;
    logic [31:0] m_pend_data;
    logic [7:0]  m_last_addr;
    logic [31:0] m_hold [4];

    logic [3:0]   g_gnt;
    logic [3:0]   g_rv;
    logic [127:0] g_rd;

    task automatic model_reset();
        m_ptr       = 0;
        m_pend      = -1;
        m_pend_data = '0;
        m_last_addr = '0;
        for (int i = 0; i < 4; i++) m_hold[i] = '0;
    endtask

    // Drive one cycle of inputs, check every output mid-cycle, advance the model.
    task automatic step(input logic [3:0] req, input logic e, input logic [31:0] addr);
        int           w;
        int           c;
        logic [3:0]   eg;
        logic [3:0]   erv;
        logic [127:0] erd;
        logic [7:0]   ema;
        core_req  = req;
        en        = e;
        core_addr = addr;
        @(negedge clk);
        w = -1;
        if (e) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (req[c] && w < 0) w = c;
            end
        end
        eg  = (w >= 0) ? 4'(1 << w) : 4'b0000;
        erv = (m_pend >= 0) ? 4'(1 << m_pend) : 4'b0000;
        ema = (w >= 0) ? addr[w*8 +: 8] : m_last_addr;
        for (int i = 0; i < 4; i++) erd[i*32 +: 32] = (i == m_pend) ? m_pend_data : m_hold[i];
        g_gnt = core_gnt;
        g_rv  = core_rvalid;
        g_rd  = core_rdata;
        chk("gnt",      128'(core_gnt),    128'(eg));
        chk("stall",    128'(core_stall),  128'(req & ~eg));
        chk("mem_en",   128'(mem_en),      128'(w >= 0));
        chk("mem_addr", 128'(mem_addr),    128'(ema));
        chk("rvalid",   128'(core_rvalid), 128'(erv));
        chk("rdata",    core_rdata,        erd);
        if (m_pend >= 0) m_hold[m_pend] = m_pend_data;
        if (w >= 0) begin
            m_ptr       = (w + 1) % 4;
            m_last_addr = addr[w*8 +: 8];
            m_pend      = w;
            m_pend_data = mem[addr[w*8 +: 8]];
        end else begin
            m_pend = -1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [7:0] a3, input logic [7:0] a2,
                                       input logic [7:0] a1, input logic [7:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    typedef struct packed {
        logic [3:0]  req;
        logic        en;
        logic [31:0] addr;
        logic [3:0]  gnt;
        logic [3:0]  rv;
    } vec_t;

    vec_t tbl [23];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) + 32'h100;
        mem[8'hEE] = 32'hDEADBEEF;
        mem_rdata  = '0;

        // single requester, core 2
        tbl[0]  = '{4'b0100, 1'b1, mk(8'h00, 8'h10, 8'h00, 8'h00), 4'b0100, 4'b0000};
        tbl[1]  = '{4'b0100, 1'b1, mk(8'h00, 8'h11, 8'h00, 8'h00), 4'b0100, 4'b0100};
        tbl[2]  = '{4'b0100, 1'b1, mk(8'h00, 8'h12, 8'h00, 8'h00), 4'b0100, 4'b0100};
        tbl[3]  = '{4'b0000, 1'b1, mk(8'h00, 8'h00, 8'h00, 8'h00), 4'b0000, 4'b0100};
        // wrap and skip from ptr=3
        tbl[4]  = '{4'b0101, 1'b1, mk(8'h00, 8'h21, 8'h00, 8'h20), 4'b0001, 4'b0000};
        tbl[5]  = '{4'b0101, 1'b1, mk(8'h00, 8'h21, 8'h00, 8'h22), 4'b0100, 4'b0001};
        tbl[6]  = '{4'b0101, 1'b1, mk(8'h00, 8'h23, 8'h00, 8'h22), 4'b0001, 4'b0100};
        tbl[7]  = '{4'b1000, 1'b1, mk(8'h30, 8'h00, 8'h00, 8'h00), 4'b1000, 4'b0001};
        // full contention from ptr=0
        tbl[8]  = '{4'b1111, 1'b1, mk(8'h43, 8'h42, 8'h41, 8'h40), 4'b0001, 4'b1000};
        tbl[9]  = '{4'b1111, 1'b1, mk(8'h43, 8'h42, 8'h41, 8'h44), 4'b0010, 4'b0001};
        tbl[10] = '{4'b1111, 1'b1, mk(8'h43, 8'h42, 8'h45, 8'h44), 4'b0100, 4'b0010};
        tbl[11] = '{4'b1111, 1'b1, mk(8'h43, 8'h46, 8'h45, 8'h44), 4'b1000, 4'b0100};
        tbl[12] = '{4'b1111, 1'b1, mk(8'h47, 8'h46, 8'h45, 8'h44), 4'b0001, 4'b1000};
        tbl[13] = '{4'b1111, 1'b1, mk(8'h47, 8'h46, 8'h45, 8'h48), 4'b0010, 4'b0001};
        tbl[14] = '{4'b1111, 1'b1, mk(8'h47, 8'h46, 8'h49, 8'h48), 4'b0100, 4'b0010};
        tbl[15] = '{4'b1111, 1'b1, mk(8'h47, 8'h4A, 8'h49, 8'h48), 4'b1000, 4'b0100};
        // enable low right after a grant to core 1
        tbl[16] = '{4'b0010, 1'b1, mk(8'h00, 8'h00, 8'h50, 8'h00), 4'b0010, 4'b1000};
        tbl[17] = '{4'b0010, 1'b0, mk(8'h00, 8'h00, 8'h51, 8'h00), 4'b0000, 4'b0010};
        tbl[18] = '{4'b1111, 1'b0, mk(8'h63, 8'h62, 8'h51, 8'h60), 4'b0000, 4'b0000};
        tbl[19] = '{4'b1111, 1'b1, mk(8'h63, 8'h62, 8'h51, 8'h60), 4'b0100, 4'b0000};
        tbl[20] = '{4'b0000, 1'b1, mk(8'h00, 8'h00, 8'h00, 8'h00), 4'b0000, 4'b0100};
        // core 3 fetches 0xDEADBEEF
        tbl[21] = '{4'b1000, 1'b1, mk(8'hEE, 8'h00, 8'h00, 8'h00), 4'b1000, 4'b0000};
        tbl[22] = '{4'b0111, 1'b1, mk(8'h00, 8'h72, 8'h71, 8'h70), 4'b0001, 4'b1000};

        rst_n     = 1'b0;
        en        = 1'b0;
        core_req  = 4'b0000;
        core_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt",      128'(core_gnt),    128'(0));
        chk("reset_rvalid",   128'(core_rvalid), 128'(0));
        chk("reset_rdata",    core_rdata,        128'(0));
        chk("reset_mem_en",   128'(mem_en),      128'(0));
        chk("reset_mem_addr", 128'(mem_addr),    128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].req, tbl[i].en, tbl[i].addr);
            chk($sformatf("vec%0d_gnt", i),    128'(g_gnt), 128'(tbl[i].gnt));
            chk($sformatf("vec%0d_rvalid", i), 128'(g_rv),  128'(tbl[i].rv));
        end

        for (int j = 0; j < 10; j++) begin
            step(4'b0111, 1'b1, mk(8'h00, 8'h82, 8'h81, 8'h80));
            chk("hold_core3", 128'(g_rd[127:96]), 128'(32'hDEADBEEF));
        end

        // Asynchronous reset while a response is in flight.
        step(4'b1111, 1'b1, mk(8'h93, 8'h92, 8'h91, 8'h90));
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("arst_rvalid",   128'(core_rvalid), 128'(0));
        chk("arst_rdata",    core_rdata,        128'(0));
        chk("arst_mem_en",   128'(mem_en),      128'(0));
        chk("arst_mem_addr", 128'(mem_addr),    128'(0));
        chk("arst_gnt",      128'(core_gnt),    128'(0));
        chk("arst_stall",    128'(core_stall),  128'(4'b1111));
        @(posedge clk);
        #2;
        chk("arst_rvalid_next", 128'(core_rvalid), 128'(0));
        rst_n = 1'b1;
        model_reset();
        step(4'b1111, 1'b1, mk(8'hA3, 8'hA2, 8'hA1, 8'hA0));
        chk("post_rst_gnt", 128'(g_gnt), 128'(4'b0001));

        for (int r = 0; r < 400; r++) begin
            step(4'($urandom), 1'($urandom_range(0, 7) != 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/progmem_arbiter.md
# progmem_arbiter

Shares one synchronous, single-port program memory between `N_CORES` pipelined cores so that one instruction array serves every fetch stage in the multicore system. Each core's fetch stage presents a request and a fetch address. The arbiter grants at most one request per cycle using round-robin priority and drives the memory port. It returns the fetched instruction one cycle later, tagged to the granted core, and raises a per-core stall while a core waits for a grant.

## Interface
- `N_CORES`, default 4: number of requesting cores; must be ≥ 2.
- `INST_W`, default `` `INST_W ``: instruction width.
- `INST_ADDR_W`, default `` `INST_ADDR_W ``: instruction address width.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: global enable; when low, no new grants are issued.
- `core_req`  in  `N_CORES`: per-core fetch request (level).
- `core_addr`  in  `N_CORES*INST_ADDR_W`: per-core fetch address; core i uses slice `[i*INST_ADDR_W +: INST_ADDR_W]`.
- `core_gnt`  out  `N_CORES`: one-hot or zero; the request is accepted this cycle.
- `core_stall`  out  `N_CORES`: equals `core_req & ~core_gnt`.
- `core_rvalid`  out  `N_CORES`: one-hot or zero; the instruction for core i is valid this cycle.
- `core_rdata`  out  `N_CORES*INST_W`: per-core instruction; slice i holds the last value returned to core i.
- `mem_en`  out  1: memory read strobe.
- `mem_addr`  out  `INST_ADDR_W`: memory read address.
- `mem_rdata`  in  `INST_W`: memory read data, valid the cycle after `mem_en`.

## Operation
- **Arbitration.** Arbitration is combinational within the issue cycle.
  - Candidates are `core_req` gated by `en`.
  - The winner is the first requesting index found searching upward from `ptr`, wrapping from `N_CORES-1` to 0.
- **Issue.** When a winner w exists:
  - `core_gnt[w]=1`, `mem_en=1`, `mem_addr=core_addr[w]`.
  - `ptr <= (w+1) mod N_CORES`.
  - `inflight_vld <= 1`, `inflight_id <= w`.
- **No winner.** `core_gnt=0`, `mem_en=0`, `mem_addr` holds its previous value (registered copy), `ptr` unchanged, `inflight_vld <= 0`.
- **Response.** When `inflight_vld=1`:
  - `core_rvalid[inflight_id]=1`.
  - `core_rdata[inflight_id]` shows `mem_rdata` combinationally (bypass) and captures it into the hold register at the end of the cycle.
  - All other `core_rdata` slices keep their hold-register value.
- **Request rules.**
  - A core holds `core_req` and `core_addr` stable until it sees `core_gnt`.
  - A core may deassert an ungranted request; this is treated as withdrawn and has no side effect.
  - A core may issue back-to-back requests.
- **Enable low.** No grants are issued and `ptr` is frozen. A response already in flight is still delivered on the following cycle.
- **Fairness.** A core holding `core_req` continuously with `en=1` is granted within `N_CORES` cycles.
- **Reset (asynchronous, any time).**
  - `ptr=0`, `inflight_vld=0`, `inflight_id=0`.
  - All `core_rdata` hold registers = 0, `core_rvalid=0`, `mem_addr` register = 0.
  - An in-flight response is dropped; no `core_rvalid` is asserted after reset for a pre-reset grant.

## Timing
- Issue-to-response latency is exactly 1 cycle: grant in cycle t gives `core_rvalid` in cycle t+1. The hold register is visible from t+2 onward.
- Throughput is one fetch per cycle total, independent of the requester pattern. The issue of cycle t+1 overlaps the response of cycle t.
- Same core granted on consecutive cycles: `core_rvalid[i]` stays high on consecutive cycles with successive data.
- `core_gnt`, `core_stall`, `mem_en` and `mem_addr` are combinational from `core_req`, `en` and `ptr`. `core_rvalid` depends only on registered state.
- Reset values of all outputs: `core_gnt=0`, `core_stall=core_req` (with `en=0`), `core_rvalid=0`, `core_rdata=0`, `mem_en=0`, `mem_addr=0`.
- `ptr` width is `$clog2(N_CORES)`. For non-power-of-two `N_CORES`, the increment wraps explicitly at `N_CORES-1`.

## Structure
- `defines.vh` gains `` `PROGMEM_N_CORES ``, used as the default for `N_CORES` at core-cluster instantiation. `` `INST_W `` and `` `INST_ADDR_W `` already live there.
- Sub-module `rr_pick`: a combinational round-robin picker.
  - Inputs: `req[N-1:0]`, `ptr`.
  - Outputs: `gnt` (one-hot), `any`, `idx`.
  - It is reused later for data-memory arbitration.
- The top level holds `ptr`, the in-flight tag, the `mem_addr` register, the hold registers and the bypass mux.

## Test plan
- **Reset.** Assert `rst_n=0` mid-run with `inflight_vld=1` → all outputs go to reset values immediately; no `core_rvalid` on the next cycle; after release, the first grant goes to core 0 when `core_req=4'b1111`.
- **Single requester.** Core 2 requests continuously, addresses 0x10, 0x11, 0x12; memory returns addr+0x100 → `core_gnt=4'b0100` every cycle; `core_rvalid[2]` from cycle t+1 with data 0x110, 0x111, 0x112; `core_stall=0`.
- **Full contention.** `core_req=4'b1111` held for 8 cycles → grants in order 0,1,2,3,0,1,2,3; each core sees exactly one `core_rvalid` per 4 cycles; the maximum stall run per core is 3.
- **Wrap and skip.** `ptr=3` with `core_req=4'b0101` → core 0 is granted, then core 2, then core 0; cores 1 and 3 are never granted.
- **Enable low.** Drop `en` the cycle after a grant to core 1 → `core_rvalid[1]` still asserted next cycle; no further `mem_en`; `ptr` unchanged; grants resume from `ptr` when `en` returns.
- **Data hold.** Core 3 receives 0xDEADBEEF, then stops requesting while cores 0–2 fetch for 10 cycles → `core_rdata[3]` remains 0xDEADBEEF throughout.
